// File: rtl/tx_gate_pkg.sv
// -----------------------------------------------------------------------------
// tx_gate_pkg
// Shared definitions for the transmit store-and-forward gate:
//   - FSM state encodings for the input (write) and output (read) sides
//   - layout of a stored FIFO word: {err, last, keep, data}
//   - constant clog2 helper used to size pointers and counters
// No ports; imported by tx_packet_gate and tx_sync_fifo.
// -----------------------------------------------------------------------------
package tx_gate_pkg;

    typedef enum logic {
        IN_PASS    = 1'b0,
        IN_DISCARD = 1'b1
    } in_state_e;

    typedef enum logic {
        OUT_IDLE = 1'b0,
        OUT_SEND = 1'b1
    } out_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Stored word: data in the low bits, then keep, then last, then err.
    function automatic int word_wbits(input int data_wbits, input int data_wbyts);
        return data_wbits + data_wbyts + 2;
    endfunction

    function automatic int keep_lsb(input int data_wbits);
        return data_wbits;
    endfunction

    function automatic int last_pos(input int data_wbits, input int data_wbyts);
        return data_wbits + data_wbyts;
    endfunction

    function automatic int err_pos(input int data_wbits, input int data_wbyts);
        return data_wbits + data_wbyts + 1;
    endfunction

endpackage

// File: rtl/tx_sync_fifo.sv
// -----------------------------------------------------------------------------
// tx_sync_fifo
// Single-clock first-word-fall-through FIFO. The head word is visible on
// rd_data whenever empty is low; rd_en pops it.
// Ports:
//   clk, reset       clock, asynchronous active-high reset (pointers only)
//   wr_en, wr_data   push a word (ignored while full)
//   full             no free entry
//   rd_en            pop the head word (ignored while empty)
//   rd_data          current head word
//   empty            no stored word
// DEPTH must be a power of 2 and at least 2.
// -----------------------------------------------------------------------------
module tx_sync_fifo
    import tx_gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = wr_en && !full;
    assign w_pop   = rd_en && !empty;
    assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/tx_packet_gate.sv
// -----------------------------------------------------------------------------
// tx_packet_gate
// Store-and-forward gate in front of the 100G MAC transmit interface. A packet
// is only released once its last beat is buffered, so TVALID toward the MAC
// never drops inside a frame. Packets longer than MAX_PKT_BEATS are cut at
// MAX_PKT_BEATS beats, the cut beat is marked last with TUSER=1 so the MAC
// aborts it, and the remaining input beats are swallowed.
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   AXIS_IN_TDATA/TKEEP/TLAST        input beat
//   AXIS_IN_TVALID/TREADY            input handshake
//   AXIS_OUT_TDATA/TKEEP/TLAST/TUSER beat toward the MAC (TUSER=abort)
//   AXIS_OUT_TVALID/TREADY           output handshake
//   out_stall                        registered: previous cycle was stalled
//   oversize_dropped                 sticky: a packet was truncated
//   packets_sent                     wrapping count of delivered last beats
// -----------------------------------------------------------------------------
module tx_packet_gate
    import tx_gate_pkg::*;
#(
    parameter int DATA_WBITS    = 512,
    parameter int DATA_WBYTS    = DATA_WBITS/8,
    parameter int FIFO_DEPTH    = 256,
    parameter int MAX_PKT_BEATS = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WBITS-1:0] AXIS_IN_TDATA,
    input  logic [DATA_WBYTS-1:0] AXIS_IN_TKEEP,
    input  logic                  AXIS_IN_TLAST,
    input  logic                  AXIS_IN_TVALID,
    output logic                  AXIS_IN_TREADY,
    output logic [DATA_WBITS-1:0] AXIS_OUT_TDATA,
    output logic [DATA_WBYTS-1:0] AXIS_OUT_TKEEP,
    output logic                  AXIS_OUT_TUSER,
    output logic                  AXIS_OUT_TLAST,
    output logic                  AXIS_OUT_TVALID,
    input  logic                  AXIS_OUT_TREADY,
    output logic                  out_stall,
    output logic                  oversize_dropped,
    output logic [31:0]           packets_sent
);

    localparam int WORD_W   = word_wbits(DATA_WBITS, DATA_WBYTS);
    localparam int KEEP_LSB = keep_lsb(DATA_WBITS);
    localparam int LAST_POS = last_pos(DATA_WBITS, DATA_WBYTS);
    localparam int ERR_POS  = err_pos(DATA_WBITS, DATA_WBYTS);
    localparam int BCW      = clog2(MAX_PKT_BEATS) + 1;
    localparam int PCW      = clog2(FIFO_DEPTH) + 1;

    localparam logic [BCW-1:0] LAST_BEAT_IDX = BCW'(MAX_PKT_BEATS - 1);
    localparam logic [BCW-1:0] BC_ONE        = BCW'(1);
    localparam logic [PCW-1:0] PC_ONE        = PCW'(1);

    in_state_e        r_in_state;
    in_state_e        w_in_state_nxt;
    out_state_e       r_out_state;
    out_state_e       w_out_state_nxt;

    logic [BCW-1:0]   r_beat_cnt;
    logic [PCW-1:0]   r_pkt_cnt;
    logic             r_out_stall;
    logic             r_oversize;
    logic [31:0]      r_packets_sent;

    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_wr_en;
    logic             w_rd_en;
    logic [WORD_W-1:0] w_wr_word;
    logic [WORD_W-1:0] w_rd_word;

    logic             w_in_hs;
    logic             w_at_limit;
    logic             w_store_last;
    logic             w_store_err;
    logic             w_pkt_in;
    logic             w_pkt_out;

    // ------------------------------------------------------------------
    // Input side
    // ------------------------------------------------------------------
    // Discarding never writes, so it keeps accepting even with a full FIFO.
    assign AXIS_IN_TREADY = !reset && ((r_in_state == IN_DISCARD) || !w_fifo_full);
    assign w_in_hs        = AXIS_IN_TVALID && AXIS_IN_TREADY;
    assign w_at_limit     = (r_beat_cnt == LAST_BEAT_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_state <= IN_PASS;
        end else begin
            r_in_state <= w_in_state_nxt;
        end
    end

    always_comb begin
        w_in_state_nxt = r_in_state;
        unique case (r_in_state)
            IN_PASS: begin
                if (w_in_hs && !AXIS_IN_TLAST && w_at_limit) begin
                    w_in_state_nxt = IN_DISCARD;
                end
            end
            IN_DISCARD: begin
                if (w_in_hs && AXIS_IN_TLAST) begin
                    w_in_state_nxt = IN_PASS;
                end
            end
            default: w_in_state_nxt = IN_PASS;
        endcase
    end

    // A real TLAST takes precedence over the length limit, so a packet of
    // exactly MAX_PKT_BEATS beats is stored intact.
    always_comb begin
        w_wr_en      = 1'b0;
        w_store_last = 1'b0;
        w_store_err  = 1'b0;
        if ((r_in_state == IN_PASS) && w_in_hs) begin
            w_wr_en      = 1'b1;
            w_store_last = AXIS_IN_TLAST || w_at_limit;
            w_store_err  = !AXIS_IN_TLAST && w_at_limit;
        end
    end

    assign w_pkt_in  = w_wr_en && w_store_last;
    assign w_wr_word = {w_store_err, w_store_last, AXIS_IN_TKEEP, AXIS_IN_TDATA};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_beat_cnt <= '0;
            r_oversize <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_beat_cnt <= w_store_last ? '0 : (r_beat_cnt + BC_ONE);
            end
            if (w_store_err) begin
                r_oversize <= 1'b1;
            end
        end
    end

    tx_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_wr_en),
        .wr_data (w_wr_word),
        .full    (w_fifo_full),
        .rd_en   (w_rd_en),
        .rd_data (w_rd_word),
        .empty   (w_fifo_empty)
    );

    // ------------------------------------------------------------------
    // Output side
    // ------------------------------------------------------------------
    // Outputs come straight off the FIFO head; the head cannot change while
    // stalled because the read pointer only moves on a handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_state <= OUT_IDLE;
        end else begin
            r_out_state <= w_out_state_nxt;
        end
    end

    always_comb begin
        w_out_state_nxt = r_out_state;
        unique case (r_out_state)
            OUT_IDLE: begin
                if ((r_pkt_cnt != '0) && !w_fifo_empty) begin
                    w_out_state_nxt = OUT_SEND;
                end
            end
            OUT_SEND: begin
                // Another whole packet already queued: continue with no bubble.
                if (w_pkt_out && (r_pkt_cnt == PC_ONE)) begin
                    w_out_state_nxt = OUT_IDLE;
                end
            end
            default: w_out_state_nxt = OUT_IDLE;
        endcase
    end

    always_comb begin
        AXIS_OUT_TVALID = (r_out_state == OUT_SEND);
        AXIS_OUT_TDATA  = w_rd_word[DATA_WBITS-1:0];
        AXIS_OUT_TKEEP  = w_rd_word[KEEP_LSB +: DATA_WBYTS];
        AXIS_OUT_TLAST  = AXIS_OUT_TVALID && w_rd_word[LAST_POS];
        AXIS_OUT_TUSER  = AXIS_OUT_TLAST && w_rd_word[ERR_POS];
        w_rd_en         = AXIS_OUT_TVALID && AXIS_OUT_TREADY;
    end

    assign w_pkt_out = w_rd_en && w_rd_word[LAST_POS];

    // Complete-packet count; a simultaneous completion on both sides cancels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pkt_cnt      <= '0;
            r_packets_sent <= '0;
            r_out_stall    <= 1'b0;
        end else begin
            case ({w_pkt_in, w_pkt_out})
                2'b10:   r_pkt_cnt <= r_pkt_cnt + PC_ONE;
                2'b01:   r_pkt_cnt <= r_pkt_cnt - PC_ONE;
                default: r_pkt_cnt <= r_pkt_cnt;
            endcase
            if (w_pkt_out) begin
                r_packets_sent <= r_packets_sent + 32'd1;
            end
            r_out_stall <= AXIS_OUT_TVALID && !AXIS_OUT_TREADY;
        end
    end

    assign out_stall        = r_out_stall;
    assign oversize_dropped = r_oversize;
    assign packets_sent     = r_packets_sent;

endmodule

// File: tb/tb_tx_packet_gate.sv
module tb_tx_packet_gate;

    localparam int DW    = 32;
    localparam int DB    = 4;
    localparam int DEPTH = 256;
    localparam int MAXB  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_data;
    logic [DB-1:0] in_keep;
    logic          in_last;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic [DB-1:0] out_keep;
    logic          out_user;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;
    logic          out_stall;
    logic          oversize;
    logic [31:0]   psent;

    always #5 clk = ~clk;

    tx_packet_gate #(
        .DATA_WBITS    (DW),
        .DATA_WBYTS    (DB),
        .FIFO_DEPTH    (DEPTH),
        .MAX_PKT_BEATS (MAXB)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .AXIS_IN_TDATA    (in_data),
        .AXIS_IN_TKEEP    (in_keep),
        .AXIS_IN_TLAST    (in_last),
        .AXIS_IN_TVALID   (in_valid),
        .AXIS_IN_TREADY   (in_ready),
        .AXIS_OUT_TDATA   (out_data),
        .AXIS_OUT_TKEEP   (out_keep),
        .AXIS_OUT_TUSER   (out_user),
        .AXIS_OUT_TLAST   (out_last),
        .AXIS_OUT_TVALID  (out_valid),
        .AXIS_OUT_TREADY  (out_ready),
        .out_stall        (out_stall),
        .oversize_dropped (oversize),
        .packets_sent     (psent)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [DB-1:0] k;
        logic          l;
        logic          e;
    } beat_t;

    typedef struct {
        logic          vin;
        logic [DW-1:0] din;
        logic          lin;
        logic          exp_ir;
        logic          exp_ov;
    } vec_t;

    vec_t  vecs[13];
    beat_t expq[$];
    beat_t part[$];

    int    total = 0;
    int    bad   = 0;
    int    cur_len;
    bit    discarding;
    bit    exp_over;
    int    exp_sent;
    bit    prev_stall;
    bit    mid_pkt;
    beat_t prev_out;
    int    rdy_mode;
    logic [15:0] seq;
    int    out_beats = 0;
    int    user_beats = 0;
    int    stall_cycles = 0;
    int    stall_pulses = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b want %0b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input beat_t act, input beat_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic finish_test();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic timeout_fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got timeout want completion", nm);
        finish_test();
        forever @(posedge clk);
    endtask

    // Reference model: packets as lists of beats, truncated at MAXB beats.
    task automatic model_reset();
        expq.delete();
        part.delete();
        cur_len    = 0;
        discarding = 1'b0;
        exp_over   = 1'b0;
        exp_sent   = 0;
        prev_stall = 1'b0;
        mid_pkt    = 1'b0;
    endtask

    task automatic flush_part();
        while (part.size() > 0) expq.push_back(part.pop_front());
    endtask

    task automatic model_accept(input logic [DW-1:0] d, input logic [DB-1:0] k, input logic l);
        if (discarding) begin
            if (l) discarding = 1'b0;
        end else begin
            cur_len++;
            if (l) begin
                part.push_back(beat_t'{d, k, 1'b1, 1'b0});
                flush_part();
                cur_len = 0;
            end else if (cur_len == MAXB) begin
                part.push_back(beat_t'{d, k, 1'b1, 1'b1});
                flush_part();
                cur_len    = 0;
                discarding = 1'b1;
                exp_over   = 1'b1;
            end else begin
                part.push_back(beat_t'{d, k, 1'b0, 1'b0});
            end
        end
    endtask

    // Called at the falling edge: checks outputs, then advances the model
    // with the handshakes that the next rising edge will perform.
    task automatic monitor();
        beat_t cur;
        beat_t e;
        logic  exp_ready;
        if (reset) begin
            chk1("rst_in_ready", in_ready, 1'b0);
            chk1("rst_out_valid", out_valid, 1'b0);
            chk1("rst_out_stall", out_stall, 1'b0);
            chk1("rst_oversize", oversize, 1'b0);
            chk32("rst_packets_sent", psent, 32'd0);
            model_reset();
            return;
        end
        exp_ready = discarding || ((part.size() + expq.size()) < DEPTH);
        chk1("in_ready", in_ready, exp_ready);
        chk1("out_stall", out_stall, prev_stall);
        chk1("oversize", oversize, exp_over);
        chk32("packets_sent", psent, exp_sent);
        cur = beat_t'{out_data, out_keep, out_last, out_user};
        if (mid_pkt) chk1("valid_hold", out_valid, 1'b1);
        if (prev_stall && out_valid) chkb("stall_stable", cur, prev_out);
        if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got %h want none", cur);
            end else begin
                e = expq.pop_front();
                chkb("out_beat", cur, e);
            end
            out_beats++;
            if (out_user) user_beats++;
            if (out_last) exp_sent++;
        end
        if (out_valid && !out_ready) stall_cycles++;
        if (out_stall) stall_pulses++;
        prev_stall = out_valid && !out_ready;
        prev_out   = cur;
        mid_pkt    = out_valid && !(out_ready && out_last);
        if (in_valid && in_ready) model_accept(in_data, in_keep, in_last);
    endtask

    task automatic cycle_acc(output bit acc);
        @(negedge clk);
        acc = in_valid && in_ready;
        monitor();
        @(posedge clk);
        #1;
        if (rdy_mode == 2) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic cycle();
        bit acc;
        cycle_acc(acc);
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [DB-1:0] k, input logic l);
        bit acc;
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_keep  = k;
        in_last  = l;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 600) begin
            cycle_acc(acc);
            n++;
        end
        in_valid = 1'b0;
        if (!acc) timeout_fail("in_accept");
    endtask

    task automatic send_pkt(input int len, input int max_gap);
        for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(0, max_gap)) cycle();
            send_beat({seq, 16'(i)}, 4'($urandom), (i == len - 1));
        end
        seq++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((expq.size() > 0 || out_valid) && n < 3000) begin
            cycle();
            n++;
        end
        if (expq.size() > 0 || out_valid) timeout_fail("drain");
        repeat (2) cycle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        bit acc;
        int ob0;
        int ub0;

        for (int r = 0; r < 13; r++) begin
            vecs[r].vin    = ((r % 4) == 0);
            vecs[r].din    = {16'hA001, 16'(r / 4)};
            vecs[r].lin    = (r == 12);
            vecs[r].exp_ir = 1'b1;
            vecs[r].exp_ov = 1'b0;
        end

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_keep   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        rdy_mode  = 1;
        seq       = 16'h0100;
        model_reset();
        repeat (3) cycle();
        @(negedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;

        // 4-beat packet, three idle cycles between beats
        for (int r = 0; r < 13; r++) begin
            in_valid = vecs[r].vin;
            in_data  = vecs[r].din;
            in_keep  = 4'hF;
            in_last  = vecs[r].lin;
            @(negedge clk);
            chk1("t1_in_ready", in_ready, vecs[r].exp_ir);
            chk1("t1_out_valid", out_valid, vecs[r].exp_ov);
            monitor();
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        n = 0;
        while (!out_valid && n < 3) begin
            cycle();
            n++;
        end
        chk1("t1_latency", out_valid, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk1("t1_burst_valid", out_valid, 1'b1);
            chk1("t1_burst_last", out_last, (i == 3));
            chk32("t1_burst_data", out_data, {16'hA001, 16'(i)});
            cycle();
        end
        chk1("t1_after_valid", out_valid, 1'b0);
        drain();
        chk32("t1_sent", psent, 32'd1);

        // oversize packet followed by a normal one
        ob0 = out_beats;
        ub0 = user_beats;
        send_pkt(12, 0);
        send_pkt(2, 0);
        drain();
        chk32("t2_out_beats", 32'(out_beats - ob0), 32'd10);
        chk32("t2_user_beats", 32'(user_beats - ub0), 32'd1);
        chk1("t2_oversize", oversize, 1'b1);
        chk32("t2_sent", psent, 32'd3);

        // fill the FIFO with the MAC stalled
        rdy_mode  = 0;
        out_ready = 1'b0;
        for (int p = 0; p < 64; p++) send_pkt(4, 0);
        in_valid = 1'b1;
        in_data  = 32'hF00D_0257;
        in_keep  = 4'hF;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk1("t3_full_ready", in_ready, 1'b0);
        end
        chk1("t3_stalled_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        rdy_mode  = 1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            cycle_acc(acc);
            n++;
        end
        in_valid = 1'b0;
        chk1("t3_257th_accepted", acc, 1'b1);
        drain();
        chk32("t3_sent", psent, 32'd68);

        // back-to-back single-beat packets
        for (int p = 0; p < 20; p++) send_pkt(1, 0);
        drain();
        chk32("t5_sent", psent, 32'd88);

        // random lengths, gaps and MAC back-pressure
        rdy_mode = 2;
        for (int p = 0; p < 40; p++) send_pkt($urandom_range(1, 12), 2);
        rdy_mode  = 1;
        out_ready = 1'b1;
        drain();
        chk32("t4_sent", psent, 32'd128);
        chk32("t4_stall_pulses", 32'(stall_pulses), 32'(stall_cycles));

        // asynchronous reset in the middle of a packet
        send_beat(32'hDEAD_0000, 4'hF, 1'b0);
        send_beat(32'hDEAD_0001, 4'hF, 1'b0);
        #1 reset = 1'b1;
        #1;
        chk1("t6_async_in_ready", in_ready, 1'b0);
        chk1("t6_async_out_valid", out_valid, 1'b0);
        chk1("t6_async_stall", out_stall, 1'b0);
        chk1("t6_async_oversize", oversize, 1'b0);
        chk32("t6_async_sent", psent, 32'd0);
        repeat (2) cycle();
        @(negedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        ob0 = out_beats;
        send_pkt(3, 1);
        drain();
        chk32("t6_out_beats", 32'(out_beats - ob0), 32'd3);
        chk32("t6_sent", psent, 32'd1);

        finish_test();
    end

endmodule

// File: doc/tx_packet_gate.md
Name: tx_packet_gate

Overview:
Store-and-forward gate on the transmit path toward the 100G Ethernet MAC. The MAC's TX interface aborts (underflows) a frame if TVALID drops mid-packet. This block buffers each packet until its last beat is stored, then emits the packet with TVALID held continuously from first to last beat. Packets longer than the configured maximum are truncated and flagged with TUSER=1 so the MAC discards them.

Parameters:
DATA_WBITS, 512, data bus width in bits
DATA_WBYTS, DATA_WBITS/8, TKEEP width
FIFO_DEPTH, 256, beat capacity; power of 2
MAX_PKT_BEATS, 128, largest legal packet in beats; must be <= FIFO_DEPTH

Ports:
clk  in  1  sole clock
reset  in  1  asynchronous, active-high reset
AXIS_IN_TDATA  in  DATA_WBITS  input beat data
AXIS_IN_TKEEP  in  DATA_WBYTS  input byte enables
AXIS_IN_TLAST  in  1  input end of packet
AXIS_IN_TVALID  in  1  input beat valid
AXIS_IN_TREADY  out  1  input beat accepted
AXIS_OUT_TDATA  out  DATA_WBITS  to MAC
AXIS_OUT_TKEEP  out  DATA_WBYTS  to MAC
AXIS_OUT_TUSER  out  1  1 = abort this frame; driven only on the last beat
AXIS_OUT_TLAST  out  1  to MAC
AXIS_OUT_TVALID  out  1  to MAC
AXIS_OUT_TREADY  in  1  from MAC
out_stall  out  1  registered; high on the cycle after AXIS_OUT_TVALID=1 with TREADY=0
oversize_dropped  out  1  sticky; set when a packet is truncated
packets_sent  out  32  count of last beats handshaken on AXIS_OUT; wraps

Behaviour:
- Reset is asynchronous and active-high. Reset applies to the whole block. While reset is high, these outputs are 0: AXIS_IN_TREADY, AXIS_OUT_TVALID, out_stall, oversize_dropped, packets_sent. FIFO pointers and counters clear. Any partially stored packet is lost and is never emitted.
- Stored word is {err, last, keep, data}.
- AXIS_IN_TREADY: 1 when the FIFO is not full, or when the input FSM is in IN_DISCARD.
- Input FSM:
  - IN_PASS: each accepted beat is written and increments beat_cnt.
  - If an accepted beat has TLAST=1, store it with last=1 and err=0. Clear beat_cnt. pkt_cnt++.
  - Else if beat_cnt == MAX_PKT_BEATS-1, store the beat with last=1 and err=1. Set oversize_dropped. pkt_cnt++. Go to IN_DISCARD.
  - IN_DISCARD: accept and drop every beat. On an accepted TLAST, return to IN_PASS.
- pkt_cnt is the number of complete packets in the FIFO; width clog2(FIFO_DEPTH)+1. If one packet completes on input and one finishes on output in the same cycle, pkt_cnt is unchanged.
- Output FSM:
  - OUT_IDLE: when pkt_cnt > 0, present the head beat and go to OUT_SEND.
  - OUT_SEND: AXIS_OUT_TVALID stays 1 every cycle until the last beat handshakes. Output fields are stable while TREADY=0. After the last-beat handshake, pkt_cnt-- and packets_sent++. Then go to OUT_IDLE, or stay in OUT_SEND with the next head beat if pkt_cnt > 1 (no bubble required; a 1-cycle bubble is allowed).
- Latency: the first output beat has TVALID=1 no later than 3 cycles after the input TLAST handshake, given an empty output stage.
- Full FIFO: since MAX_PKT_BEATS <= FIFO_DEPTH, a full FIFO always holds at least one complete packet, so there is no deadlock.
- AXIS_OUT_TUSER = err on the last beat, 0 on all other beats.
- Output order equals input order. TKEEP and TDATA pass through unaltered.

Decomposition:
- Shared package (tx_gate_pkg):
  - word field offsets/width: DATA_WBITS + DATA_WBYTS + 2
  - FSM state encodings: IN_PASS/IN_DISCARD, OUT_IDLE/OUT_SEND
  - clog2 function
- One sub-module, tx_sync_fifo:
  - single-clock, first-word-fall-through memory FIFO
  - async active-high reset on pointers and flags
  - ports: wr_en/wr_data/full, rd_en/rd_data/empty

Test Plan:
- 4-beat packet with 3 idle cycles between input beats, TREADY=1 -> AXIS_OUT_TVALID stays 0 until beat 4 is accepted, then 4 consecutive beats; TUSER=0; packets_sent=1.
- MAX_PKT_BEATS=8, 12-beat packet then a 2-beat packet -> 8 output beats, beat 8 has TLAST=1 and TUSER=1; input beats 9–12 accepted with TREADY=1 and dropped; oversize_dropped=1; the 2-beat packet follows intact with TUSER=0.
- AXIS_OUT_TREADY held 0, stream 64 four-beat packets (256 beats), then 1 more beat -> AXIS_IN_TREADY=0 after 256 beats; on release, 64 packets emerge in order; packets_sent=64; then the 257th beat is accepted.
- Random AXIS_OUT_TREADY toggling during a 16-beat packet -> output fields stable while stalled; TVALID never drops mid-packet; out_stall pulses once per stall cycle.
- 20 back-to-back single-beat packets -> pkt_cnt never exceeds 20; simultaneous in/out completions leave the count correct; all 20 emitted with TLAST=1.
- Assert reset asynchronously after beat 2 of a 5-beat packet -> all outputs 0 immediately; after release, that packet is never emitted; next packet passes normally.
